// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves data-memory wait (with timeout fault), taken branch/jump and
// load-use hazards. Pipeline controls are combinational from the FSM state and
// the current hazard inputs. Two saturating statistics counters are kept.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,  // legal range 2..255
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_write_en,
  output logic             id_ex_flush,
  output logic             ex_mem_write_en,
  output logic             mem_wb_bubble,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_FAULT
  } state_t;

  // Last wait count that is still tolerated before the access is declared hung.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic mem_stall;
  logic load_use;
  logic pc_we, if_id_we, if_id_fl, id_ex_we, id_ex_fl, ex_mem_we, bubble;

  assign mem_stall = mem_req & ~mem_ready;

  // A load in EX whose destination is a real register read by the ID instruction.
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Pipeline control decode: fault > mem_stall > branch_taken > load_use.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    // The defaults are the safe freeze pattern used in reset and FAULT.
    pc_we     = 1'b0;
    if_id_we  = 1'b0;
    if_id_fl  = 1'b0;
    id_ex_we  = 1'b0;
    id_ex_fl  = 1'b0;
    ex_mem_we = 1'b0;
    bubble    = 1'b1;
    if (!reset && state_q != ST_FAULT) begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      bubble    = 1'b0;
      if (mem_stall) begin
        // Freeze everything upstream of MEM; branch/load-use re-evaluate later
        // because the stage contents are held.
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_mem_we = 1'b0;
        bubble    = 1'b1;
      end else if (branch_taken) begin
        // PC keeps loading so the branch target is fetched next.
        if_id_fl = 1'b1;
        id_ex_fl = 1'b1;
      end else if (load_use) begin
        // Hold IF/ID and PC one cycle, insert a bubble; the load moves on.
        pc_we    = 1'b0;
        if_id_we = 1'b0;
        id_ex_fl = 1'b1;
      end
    end
  end

  // Next-state logic for the memory-wait FSM and the saturating counters.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_WAIT: begin
        if (mem_stall && wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_FAULT;
          wait_cnt_d = 8'd0;
        end else if (mem_stall) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
    if (state_q != ST_FAULT && !pc_we && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (state_q != ST_FAULT && !mem_stall && branch_taken && flush_count_q != '1)
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  // State and counter registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= 8'd0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign pc_write_en     = pc_we;
  assign if_id_write_en  = if_id_we;
  assign if_id_flush     = if_id_fl;
  assign id_ex_write_en  = id_ex_we;
  assign id_ex_flush     = id_ex_fl;
  assign ex_mem_write_en = ex_mem_we;
  assign mem_wb_bubble   = bubble;
  assign fault           = (state_q == ST_FAULT);
  assign stall_cycles    = stall_cycles_q;
  assign flush_count     = flush_count_q;

endmodule
